// File: rtl/enco_arb_pkg.sv
// Shared types and helpers for the four-way encode/decode datapath arbiter.
package enco_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // 4:2 encode of a one-hot vector; an all-zero vector encodes to 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr (wrapping 3 -> 0) wins.
module rr_pick4
    import enco_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    // Rotate requests so ptr sits at bit 0, find the lowest set bit, rotate back.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dbl     = {req, req} >> ptr;
        rot     = dbl[N_REQ-1:0];
        off     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        any     = |req;
        win_idx = any ? (ptr + off) : '0;
        win_oh  = any ? (N_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/enco_arb4.sv
// Round-robin arbiter sharing the encode/decode datapath among four
// requesters. One holder at a time; grant ends on release, on the holder
// dropping its request, or on a forced revoke after MAX_HOLD cycles. Every
// grant is followed by one empty turnaround cycle.
module enco_arb4
    import enco_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8   // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    arb_state_t       state_q,    state_d;
    logic [IDX_W-1:0] ptr_q,      ptr_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q,      gnt_d;
    logic [IDX_W-1:0] gnt_idx_q,  gnt_idx_d;
    logic             timeout_q,  timeout_d;

    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             release_hit;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // Holder lets go either by strobing its own rel bit or by dropping req.
    assign release_hit = rel[gnt_idx_q] | ~req[gnt_idx_q];

    // State register and all registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: arbitration, hold counting, release and revoke.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt_d      = win_oh;
                    gnt_idx_d  = onehot_to_idx(win_oh);
                    ptr_d      = win_idx + 1'b1;
                    hold_cnt_d = 8'd1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (release_hit) begin
                    // Release beats a coincident revoke: no timeout pulse.
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    hold_cnt_d = '0;
                    state_d    = GAP;
                end else if (hold_cnt_q == 8'(MAX_HOLD)) begin
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                    state_d    = GAP;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output drive straight from the registers.
    always_comb begin
        gnt     = gnt_q;
        gnt_idx = gnt_idx_q;
        gnt_vld = |gnt_q;
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_enco_arb4.sv
// Self-checking bench for enco_arb4: directed scenarios followed by a
// randomized run, all compared against a behavioural holder/pointer model.
module tb_enco_arb4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: who holds (-1 none), whether we are in the turnaround cycle,
    // next priority start, cycles held so far, and the revoke pulse.
    int m_holder = -1;
    int m_gap    = 0;
    int m_ptr    = 0;
    int m_hold   = 0;
    int m_to     = 0;

    enco_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic rn);
        if (!rn) begin
            m_holder = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_holder >= 0) begin
                if (l[m_holder] || !r[m_holder]) begin
                    m_holder = -1; m_gap = 1;
                end else if (m_hold == MAX_HOLD) begin
                    m_holder = -1; m_gap = 1; m_to = 1;
                end else begin
                    m_hold++;
                end
            end else if (m_gap != 0) begin
                m_gap = 0;
            end else if (r != 4'd0) begin
                for (int k = 0; k < 4; k++) begin
                    automatic int i = (m_ptr + k) % 4;
                    if (r[i]) begin
                        m_holder = i; m_ptr = (i + 1) % 4; m_hold = 1;
                        break;
                    end
                end
            end
        end
    endtask

    // One clock: compare at the falling edge, drive new inputs, advance model.
    task automatic tick(input logic [3:0] r, input logic [3:0] l, input logic rn);
        @(negedge clk);
        check("m_gnt",     32'(gnt),     (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
        check("m_gnt_idx", 32'(gnt_idx), (m_holder >= 0) ? 32'(m_holder) : 32'd0);
        check("m_gnt_vld", 32'(gnt_vld), (m_holder >= 0) ? 32'd1 : 32'd0);
        check("m_timeout", 32'(timeout), 32'(m_to));
        req   = r;
        rel   = l;
        rst_n = rn;
        @(posedge clk);
        model_step(r, l, rn);
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] exp);
        #1;
        check(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic expect_to(input string tag, input logic exp);
        #1;
        check(tag, 32'(timeout), 32'(exp));
    endtask

    initial begin
        logic [3:0] r_q;

        rst_n = 1'b0;
        req   = 4'b1111;
        rel   = 4'b0000;
        @(posedge clk);
        model_step(4'b1111, 4'b0000, 1'b0);

        // Reset held two cycles with all requests up.
        tick(4'b1111, 4'b0000, 1'b0); expect_gnt("rst_gnt0", 4'b0000); expect_to("rst_to0", 1'b0);
        tick(4'b1111, 4'b0000, 1'b0); expect_gnt("rst_gnt1", 4'b0000);
        tick(4'b1111, 4'b0000, 1'b1); expect_gnt("first_gnt", 4'b0001);

        // Round-robin with everybody requesting; each holder releases at once.
        for (int k = 1; k <= 4; k++) begin
            tick(4'b1111, 4'(1 << ((k - 1) % 4)), 1'b1); expect_gnt("rr_rel", 4'b0000);
            tick(4'b1111, 4'b0000, 1'b1);                 expect_gnt("rr_gap", 4'b0000);
            tick(4'b1111, 4'b0000, 1'b1);                 expect_gnt("rr_order", 4'(1 << (k % 4)));
            check("rr_idx", 32'(gnt_idx), 32'(k % 4));
        end

        // Grant idx 2, then only 0 and 1 request: wraps to 0, then 1.
        tick(4'b1111, 4'b0001, 1'b1);
        tick(4'b0100, 4'b0000, 1'b1);
        tick(4'b0100, 4'b0000, 1'b1); expect_gnt("wrap_g2", 4'b0100);
        tick(4'b0011, 4'b0000, 1'b1); expect_gnt("wrap_drop", 4'b0000);
        tick(4'b0011, 4'b0000, 1'b1);
        tick(4'b0011, 4'b0000, 1'b1); expect_gnt("wrap_g0", 4'b0001);
        tick(4'b0011, 4'b0001, 1'b1);
        tick(4'b0011, 4'b0000, 1'b1);
        tick(4'b0011, 4'b0000, 1'b1); expect_gnt("wrap_g1", 4'b0010);

        // Forced revoke: grant visible exactly MAX_HOLD cycles.
        tick(4'b0100, 4'b0000, 1'b1);
        tick(4'b0100, 4'b0000, 1'b1);
        tick(4'b0100, 4'b0000, 1'b1); expect_gnt("to_grant", 4'b0100);
        for (int c = 2; c <= MAX_HOLD; c++) begin
            tick(4'b0100, 4'b0000, 1'b1); expect_gnt("to_hold", 4'b0100);
        end
        tick(4'b0100, 4'b0000, 1'b1); expect_gnt("to_drop", 4'b0000); expect_to("to_pulse", 1'b1);
        tick(4'b0100, 4'b0000, 1'b1); expect_gnt("to_gap", 4'b0000); expect_to("to_pulse_end", 1'b0);
        tick(4'b0100, 4'b0000, 1'b1); expect_gnt("to_regrant", 4'b0100);

        // Release on the same edge the hold limit is reached: no pulse.
        for (int c = 2; c <= MAX_HOLD; c++) tick(4'b0100, 4'b0000, 1'b1);
        tick(4'b0100, 4'b0100, 1'b1); expect_gnt("sim_rel", 4'b0000); expect_to("sim_no_to", 1'b0);
        tick(4'b0100, 4'b0000, 1'b1);
        tick(4'b0100, 4'b0000, 1'b1); expect_gnt("sim_regrant", 4'b0100);

        // Non-holder rel ignored; holder dropping req releases.
        tick(4'b0010, 4'b0000, 1'b1);
        tick(4'b0010, 4'b0000, 1'b1);
        tick(4'b0010, 4'b0000, 1'b1); expect_gnt("nh_grant1", 4'b0010);
        tick(4'b0010, 4'b1000, 1'b1); expect_gnt("nh_ignored", 4'b0010);
        tick(4'b0000, 4'b0000, 1'b1); expect_gnt("nh_dropreq", 4'b0000); expect_to("nh_no_to", 1'b0);
        tick(4'b0000, 4'b0000, 1'b1);

        // Reset mid-grant at hold count 5: grant drops, pointer returns to 0.
        tick(4'b0010, 4'b0000, 1'b1); expect_gnt("mr_grant", 4'b0010);
        for (int c = 0; c < 4; c++) tick(4'b0010, 4'b0000, 1'b1);
        tick(4'b0010, 4'b0000, 1'b0); expect_gnt("mr_drop", 4'b0000); expect_to("mr_no_to", 1'b0);
        tick(4'b1111, 4'b0000, 1'b1); expect_gnt("mr_ptr0", 4'b0001);

        // Randomized run with sticky requests, sparse releases, rare resets.
        r_q = 4'b1111;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) r_q = 4'($urandom);
            tick(r_q,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                 ($urandom_range(0, 99) != 0));
        end
        tick(4'b0000, 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
